// File: rtl/mt9v034_i2c_config.sv
// Two-wire configuration master for the MT9V034 sensor: walks an external register
// table and issues one 16-bit register write per entry, then reports done or the NACKed entry.
module mt9v034_i2c_config #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned QTR      = 60,
    parameter logic [7:0]  DEV_ADDR = 8'h90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_data,
    input  logic        sda_i,
    output logic        scl_oe,
    output logic        sda_oe,
    output logic        busy,
    output logic        done,
    output logic        nack_err,
    output logic [7:0]  err_index
);
    localparam int unsigned QW        = $clog2(QTR);
    localparam logic [QW-1:0] LAST_Q  = QW'(QTR - 1);
    localparam logic [7:0]  LAST_ADDR = 8'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [23:0]   shift_q, shift_d;
    logic          nack_q, nack_d;
    logic [7:0]    addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          nack_err_q, nack_err_d;
    logic [7:0]    err_index_q, err_index_d;
    logic          scl_oe_q, scl_oe_d;
    logic          sda_oe_q, sda_oe_d;

    logic q_last;
    logic bit_last;
    logic tx_bit;

    assign q_last   = (qcnt_q == LAST_Q);
    assign bit_last = q_last && (quarter_q == 2'd3);
    // Byte 0 is the fixed device address; bytes 1..3 come MSB-first out of the shift register.
    assign tx_bit   = (byte_q == 2'd0) ? DEV_ADDR[3'd7 - bit_q] : shift_q[23];

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        qcnt_d      = q_last ? '0 : qcnt_q + 1'b1;
        quarter_d   = q_last ? quarter_q + 2'd1 : quarter_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
        nack_d      = nack_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        nack_err_d  = nack_err_q;
        err_index_d = err_index_q;
        scl_oe_d    = 1'b0;
        sda_oe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                qcnt_d    = '0;
                quarter_d = '0;
                if (start) begin
                    done_d      = 1'b0;
                    nack_err_d  = 1'b0;
                    err_index_d = '0;
                    addr_d      = '0;
                    busy_d      = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (qcnt_q == '0 && quarter_q == 2'd0) begin
                    shift_d = rom_data;
                    nack_d  = 1'b0;
                end
                scl_oe_d = (quarter_q == 2'd3);
                sda_oe_d = quarter_q[1];
                if (bit_last) begin
                    state_d = S_BYTE;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            S_BYTE: begin
                scl_oe_d = ~quarter_q[1];
                sda_oe_d = ~tx_bit;
                if (bit_last) begin
                    if (byte_q != 2'd0) shift_d = {shift_q[22:0], 1'b0};
                    if (bit_q == 3'd7) state_d = S_ACK;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_ACK: begin
                scl_oe_d = ~quarter_q[1];
                if (q_last && quarter_q == 2'd2) nack_d = sda_i;
                if (bit_last) begin
                    if (nack_q || byte_q == 2'd3) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_BYTE;
                        byte_d  = byte_q + 2'd1;
                        bit_d   = '0;
                    end
                end
            end
            S_STOP: begin
                scl_oe_d = ~quarter_q[1];
                sda_oe_d = (quarter_q != 2'd3);
                if (bit_last) begin
                    if (nack_q) begin
                        state_d     = S_ERROR;
                        busy_d      = 1'b0;
                        nack_err_d  = 1'b1;
                        err_index_d = addr_q;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (bit_last) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        state_d = S_START;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                qcnt_d    = '0;
                quarter_d = '0;
                // A fresh sequence needs start to fall first.
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pad enables are registered so the open-drain drivers never see decode glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            qcnt_q      <= '0;
            quarter_q   <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            shift_q     <= '0;
            nack_q      <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            nack_err_q  <= 1'b0;
            err_index_q <= '0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            quarter_q   <= quarter_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            shift_q     <= shift_d;
            nack_q      <= nack_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            nack_err_q  <= nack_err_d;
            err_index_q <= err_index_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign rom_addr  = addr_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign nack_err  = nack_err_q;
    assign err_index = err_index_q;

endmodule
